add_seq_ctrl: RTL
=================

// Module: add_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer that performs a WIDTH-bit add (a + b + ci) with a single add2b
//  2-bit ripple slice. It processes two bits per clock, LSB pair first, with the carry
//  registered between slices. A start/ready/done handshake lets a bus-side master or
//  testbench issue operations. Sits between operand registers and the shared add2b datapath.
// PARAMETERS
//  WIDTH   8   operand/result width; must be even and >= 2 (elaboration $error otherwise)
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; accepted only in a cycle where ready=1
//  a       in   WIDTH  operand A, sampled on the accepted start edge
//  b       in   WIDTH  operand B, sampled on the accepted start edge
//  ci      in   1      carry-in, sampled on the accepted start edge
//  ready   out  1      1 in IDLE (can accept start)
//  busy    out  1      1 in RUN
//  done    out  1      1-cycle pulse; sum/co are valid in this cycle
//  sum     out  WIDTH  result, registered, held until the next accepted start
//  co      out  1      carry-out, registered, held like sum
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; ready=1; busy=0; done=0; sum=0; co=0;
//    operand shift regs, carry reg and slice counter are cleared. Reset mid-RUN aborts
//    with no done pulse.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE --start--> RUN : load a_sh<=a, b_sh<=b, c_reg<=ci, cnt<=0, sum<=0, co<=0.
//    RUN : add2b gets x=a_sh[1:0], y=b_sh[1:0], ci=c_reg. Each clock:
//      a_sh,b_sh >>= 2; sum <= {slice_sum, sum[WIDTH-1:2]}; c_reg <= slice_co; cnt++.
//      When cnt == WIDTH/2-1, the same edge also sets co <= slice_co and moves to DONE.
//    DONE : done=1 for exactly one cycle, then IDLE unconditionally.
//  - Latency: start accepted at edge E0; RUN occupies WIDTH/2 cycles; done is high in the
//    cycle after edge E0+WIDTH/2 (WIDTH=8: done visible 5 cycles after start asserted).
//  - Throughput: one op every WIDTH/2+2 cycles (start can be accepted in the cycle after DONE).
//  - start while ready=0 (RUN or DONE) is ignored; operands are not re-sampled.
//  - a/b/ci changes during RUN have no effect.
//  - sum/co are intermediate during RUN; valid only from done until the next accepted start.
//  - ready, busy, done are decoded from state and are mutually exclusive; exactly one is high.
//  - Arithmetic: result = (a + b + ci) mod 2^WIDTH; co = bit WIDTH of the full sum.
//  - cnt width = $clog2(WIDTH/2), minimum 1; cnt never wraps within an operation.
// STRUCTURE
//  - add_seq_defs.vh (`include): state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//    ST_DONE is followed by a default branch to ST_IDLE.
//  - Sub-module: one add2b instance (the existing 2-bit ripple adder built from fac).
//    No other datapath arithmetic is in this block.
//  - Single always block for state/counter/shift regs, async reset on negedge rst_n;
//    outputs are decoded combinationally from state.
// TESTING (add_seq_ctrl_tb, WIDTH=8, clk period 10)
//  1 reset: rst_n=0 -> ready=1, busy=0, done=0, sum=8'h00, co=0; rst_n=1 and idle for
//    3 cycles -> unchanged.
//  2 a=8'h5A, b=8'h3C, ci=0, start 1 cycle -> busy for 4 cycles, done 1 cycle,
//    sum=8'h96, co=0, held after done.
//  3 a=8'hFF, b=8'h01, ci=0 -> sum=8'h00, co=1; a=8'hFF, b=8'hFF, ci=1 -> sum=8'hFF, co=1.
//  4 start held high through RUN with new a=8'h11 mid-op -> first result unaffected;
//    second op starts in the cycle after DONE with a=8'h11 sampled.
//  5 rst_n pulsed low during 2nd RUN cycle -> immediate IDLE, no done pulse, sum=0;
//    next op 8'h01+8'h02 -> 8'h03.
//  6 exhaustive check vs a+b+ci over all a, b, ci (WIDTH=4 build as well); each done pulse
//    matches the reference sum; no done without a prior accepted start.

Source files
------------

// File: rtl/add_seq_ctrl_pkg.sv
// Shared types and helpers for the 2-bit-per-clock add sequencer.
package add_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Slice counter width: enough to count WIDTH/2 slices, never narrower than 1 bit.
   function automatic int cnt_width(input int width);
      return (width / 2 > 1) ? $clog2(width / 2) : 1;
   endfunction

endpackage

// File: rtl/add_seq_ctrl_add2b.sv
// 2-bit ripple-carry adder slice built from two full-adder cells.

module fac (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module add2b (
   input  logic [1:0] x,
   input  logic [1:0] y,
   input  logic       ci,
   output logic [1:0] s,
   output logic       co
);

   logic c_mid;

   fac u_fac0 (.a(x[0]), .b(y[0]), .ci(ci),    .s(s[0]), .co(c_mid));
   fac u_fac1 (.a(x[1]), .b(y[1]), .ci(c_mid), .s(s[1]), .co(co));

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder: feeds operand pairs LSB-first through one add2b
// slice, carry registered between slices, with a start/ready/done handshake.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  ST_IDLE | ready=1, waiting for start; operands sampled on start
//  ST_RUN  | one 2-bit slice per clock, WIDTH/2 clocks
//  ST_DONE | done=1 for one cycle, sum/co final; back to ST_IDLE

module add_seq_ctrl
   import add_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH / 2 - 1);

   if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
      $error("add_seq_ctrl: WIDTH must be even and >= 2");
   end

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, sum_nx;
   logic             c_reg;
   logic [CW-1:0]    cnt;
   logic [1:0]       slice_sum;
   logic             slice_co;
   logic             last_slice;

   add2b u_add2b (
      .x  (a_sh[1:0]),
      .y  (b_sh[1:0]),
      .ci (c_reg),
      .s  (slice_sum),
      .co (slice_co)
   );

   // New slice result enters at the MSB end; after WIDTH/2 shifts the word is aligned.
   if (WIDTH > 2) begin : g_sum_wide
      assign sum_nx = {slice_sum, sum[WIDTH-1:2]};
   end else begin : g_sum_narrow
      assign sum_nx = slice_sum;
   end

   assign last_slice = (cnt == CNT_LAST);

   // State, slice counter, operand shifters, carry and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         c_reg <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         co    <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  c_reg <= ci;
                  cnt   <= '0;
                  sum   <= '0;
                  co    <= 1'b0;
               end
            end
            ST_RUN: begin
               a_sh  <= a_sh >> 2;
               b_sh  <= b_sh >> 2;
               sum   <= sum_nx;
               c_reg <= slice_co;
               if (last_slice) begin
                  co <= slice_co;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state and handshake outputs decoded from state.
   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) state_nx = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last_slice) state_nx = ST_DONE;
         end
         ST_DONE: begin
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule
